// File: rtl/skolem_witness_gen_pkg.sv
// Shared types and bit positions for the Skolem witness generator.
// No logic with latency; pure declarations plus the relation function.
// No flow control here; the FSM and interface own the handshakes.
package skolem_pkg;

   localparam int X_W = 4;
   localparam int I_W = 9;

   // x_in = {x_6,x_5,x_4,x_0}
   localparam int XB_X0 = 0;
   localparam int XB_X4 = 1;
   localparam int XB_X5 = 2;
   localparam int XB_X6 = 3;

   // i_out = {i_12,i_11,i_10,i_9,i_8,i_7,i_3,i_2,i_1}
   localparam int IB_I1  = 0;
   localparam int IB_I2  = 1;
   localparam int IB_I3  = 2;
   localparam int IB_I7  = 3;
   localparam int IB_I8  = 4;
   localparam int IB_I9  = 5;
   localparam int IB_I10 = 6;
   localparam int IB_I11 = 7;
   localparam int IB_I12 = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Feedback triple, MSB first as {i_10,i_11,i_12}
   typedef struct packed {
      logic i10;
      logic i11;
      logic i12;
   } fb_t;

   // Full adder+feedback relation; i_2 is deliberately unconstrained.
   function automatic logic relation_holds(input logic [X_W-1:0] x, input logic [I_W-1:0] i);
      logic x0, x4, x5, x6, c1, ok;
      x0 = x[XB_X0];
      x4 = x[XB_X4];
      x5 = x[XB_X5];
      x6 = x[XB_X6];
      c1 = x0 & x5;
      ok = 1'b1;
      ok &= (i[IB_I7] == (x0 ^ x5));
      ok &= (i[IB_I8] == (c1 ^ x4 ^ x6));
      ok &= (i[IB_I3] == ((x4 & x6) | (c1 & (x4 ^ x6))));
      ok &= (i[IB_I1] == ~i[IB_I9]);
      ok &= (i[IB_I10] == (x0 | i[IB_I12]));
      ok &= (i[IB_I11] == (x4 & i[IB_I10]));
      ok &= (i[IB_I12] == (x5 | i[IB_I11]));
      return ok;
   endfunction

endpackage

// File: rtl/skolem_witness_gen_if.sv
// Request/result bundle between stimulus source and witness generator.
// No latency; wiring only.
// Request side is valid/ready, result side is valid/ready with hold-until-accepted.
interface skolem_witness_gen_if #(
   parameter int CNT_W = 16
);
   import skolem_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [X_W-1:0]   x_in;
   logic             out_valid;
   logic             out_ready;
   logic [I_W-1:0]   i_out;
   logic             out_ok;
   logic             out_err;
   logic [CNT_W-1:0] n_solved;
   logic [CNT_W-1:0] n_failed;

   // Generator side
   modport slave (
      input  in_valid, x_in, out_ready,
      output in_ready, out_valid, i_out, out_ok, out_err, n_solved, n_failed
   );

   // Stimulus / consumer side
   modport master (
      output in_valid, x_in, out_ready,
      input  in_ready, out_valid, i_out, out_ok, out_err, n_solved, n_failed
   );

endinterface

// File: rtl/skolem_witness_gen_fixpoint_step.sv
// One Jacobi step of the feedback triple plus the feed-forward adder bits.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module skolem_fixpoint_step
   import skolem_pkg::*;
(
   input  logic [X_W-1:0] x,
   input  fb_t            fb,
   output fb_t            nxt,
   output logic           i_7,
   output logic           i_8,
   output logic           i_3
);

   logic x0, x4, x5, x6, c1;

   assign x0 = x[XB_X0];
   assign x4 = x[XB_X4];
   assign x5 = x[XB_X5];
   assign x6 = x[XB_X6];

   // All three next values come from the current triple (Jacobi, not Gauss-Seidel)
   always_comb begin
      nxt.i10 = x0 | fb.i12;
      nxt.i11 = x4 & fb.i10;
      nxt.i12 = x5 | fb.i11;
   end

   // Two-bit adder slice: x0+x5 feeds the carry into x4+x6
   always_comb begin
      c1  = x0 & x5;
      i_7 = x0 ^ x5;
      i_8 = c1 ^ x4 ^ x6;
      i_3 = (x4 & x6) | (c1 & (x4 ^ x6));
   end

endmodule

// File: rtl/skolem_witness_gen.sv
// Produces an i-vector satisfying the adder+feedback relation for a latched x.
// Latency: N iteration cycles (1..MAX_ITER) plus one check cycle, then result held.
// Single outstanding request: in_ready only in IDLE; result held until out_ready.
module skolem_witness_gen
   import skolem_pkg::*;
#(
   parameter int MAX_ITER = 4,
   parameter bit I9_VAL   = 1'b0,
   parameter bit I2_VAL   = 1'b0,
   parameter int CNT_W    = 16
)(
   input  logic                clk,
   input  logic                rst,
   skolem_witness_gen_if.slave bus
);

   state_t           state_q, state_d;
   logic [X_W-1:0]   x_q;
   fb_t              fb_q, fb_nxt;
   logic [3:0]       iter_q;
   logic             err_q;
   logic [I_W-1:0]   i_out_q, cand;
   logic             ok_q;
   logic [CNT_W-1:0] n_solved_q, n_failed_q;
   logic             ff_i7, ff_i8, ff_i3;

   logic accept, step, abort, capture, retire;

   skolem_fixpoint_step u_step (
      .x   (x_q),
      .fb  (fb_q),
      .nxt (fb_nxt),
      .i_7 (ff_i7),
      .i_8 (ff_i8),
      .i_3 (ff_i3)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and control strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      abort   = 1'b0;
      capture = 1'b0;
      retire  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ITER;
            end
         end
         ITER: begin
            if (fb_nxt == fb_q) begin
               state_d = CHECK;
            end else if (iter_q == 4'(MAX_ITER - 1)) begin
               abort   = 1'b1;
               state_d = CHECK;
            end else begin
               step = 1'b1;
            end
         end
         CHECK: begin
            capture = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Candidate witness: converged (or aborted) triple, adder bits, constants
   always_comb begin
      cand         = '0;
      cand[IB_I1]  = ~I9_VAL;
      cand[IB_I2]  = I2_VAL;
      cand[IB_I3]  = ff_i3;
      cand[IB_I7]  = ff_i7;
      cand[IB_I8]  = ff_i8;
      cand[IB_I9]  = I9_VAL;
      cand[IB_I10] = fb_q.i10;
      cand[IB_I11] = fb_q.i11;
      cand[IB_I12] = fb_q.i12;
   end

   // Datapath: latch x, iterate the triple, register the checked result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q     <= '0;
         fb_q    <= '0;
         iter_q  <= '0;
         err_q   <= 1'b0;
         i_out_q <= '0;
         ok_q    <= 1'b0;
      end else begin
         if (accept) begin
            x_q    <= bus.x_in;
            fb_q   <= '0;
            iter_q <= '0;
            err_q  <= 1'b0;
         end
         if (step) begin
            fb_q   <= fb_nxt;
            iter_q <= iter_q + 4'd1;
         end
         if (abort) err_q <= 1'b1;
         if (capture) begin
            i_out_q <= cand;
            // A non-converged triple never reports success, even if it happens to satisfy
            ok_q    <= relation_holds(x_q, cand) & ~err_q;
         end
      end
   end

   // Saturating outcome counters, bumped when the consumer takes a result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_solved_q <= '0;
         n_failed_q <= '0;
      end else if (retire) begin
         if (ok_q) begin
            if (n_solved_q != '1) n_solved_q <= n_solved_q + 1'b1;
         end else begin
            if (n_failed_q != '1) n_failed_q <= n_failed_q + 1'b1;
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE) & ~rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.i_out     = i_out_q;
   assign bus.out_ok    = ok_q;
   assign bus.out_err   = err_q;
   assign bus.n_solved  = n_solved_q;
   assign bus.n_failed  = n_failed_q;

endmodule
